hc595_serializer: RTL and testbench

HC595_SERIALIZER -- requirements
Module: hc595_serializer

---
 rtl/hc595_serializer_if.sv | 21 ++
 rtl/hc595_serializer.sv | 146 ++++++++++++++
 tb/tb_hc595_serializer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hc595_serializer_if.sv
// Parallel-load and 74HC595 pin bundle for hc595_serializer.
// Busy/Done report the transfer status back to the upstream LED-state stage.
interface hc595_serializer_if;
    logic [7:0] Data;
    logic       Load;
    logic       Busy;
    logic       Done;
    logic       SER;
    logic       SRCLK;
    logic       RCLK;

    modport master (
        output Data, Load,
        input  Busy, Done, SER, SRCLK, RCLK
    );

    modport slave (
        input  Data, Load,
        output Busy, Done, SER, SRCLK, RCLK
    );
endinterface

// File: rtl/hc595_serializer.sv
// Serialises one byte into an external 74HC595: 8 SRCLK pulses then one RCLK latch pulse.
//   state    | meaning
//   IDLE     | waiting for Load
//   SHIFT_LO | SRCLK low, current bit held on SER
//   SHIFT_HI | SRCLK high, chip has shifted the bit
//   LATCH    | RCLK high, storage register updates
//   DONE     | one-cycle completion pulse; a new Load is accepted here
module hc595_serializer #(
    parameter int CLK_DIV   = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              CLK,
    input  logic              Rst,
    hc595_serializer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       ser_q, ser_d;
    logic       srclk_q, srclk_d;
    logic       rclk_q, rclk_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       phase_end;

    assign phase_end = (cnt_q == DIV_LAST);

    always_ff @(posedge CLK or negedge Rst) begin
        if (!Rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            ser_q   <= 1'b0;
            srclk_q <= 1'b0;
            rclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            ser_q   <= ser_d;
            srclk_q <= srclk_d;
            rclk_q  <= rclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ser_d   = ser_q;
        srclk_d = srclk_q;
        rclk_d  = rclk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                srclk_d = 1'b0;
                rclk_d  = 1'b0;
                if (bus.Load) begin
                    state_d = SHIFT_LO;
                    shreg_d = bus.Data;
                    ser_d   = MSB_FIRST ? bus.Data[7] : bus.Data[0];
                    busy_d  = 1'b1;
                    cnt_d   = 8'd0;
                    bit_d   = 3'd0;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                    srclk_d = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    srclk_d = 1'b0;
                    cnt_d   = 8'd0;
                    if (bit_q == 3'd7) begin
                        state_d = LATCH;
                        rclk_d  = 1'b1;
                    end else begin
                        // next bit goes out together with the SRCLK fall
                        state_d = SHIFT_LO;
                        bit_d   = bit_q + 3'd1;
                        if (MSB_FIRST) begin
                            shreg_d = {shreg_q[6:0], 1'b0};
                            ser_d   = shreg_q[6];
                        end else begin
                            shreg_d = {1'b0, shreg_q[7:1]};
                            ser_d   = shreg_q[1];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_d = DONE;
                    rclk_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                srclk_d = 1'b0;
                rclk_d  = 1'b0;
            end
        endcase
    end

    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.SER   = ser_q;
    assign bus.SRCLK = srclk_q;
    assign bus.RCLK  = rclk_q;
endmodule

// File: tb/tb_hc595_serializer.sv
// Directed bench for hc595_serializer: two instances (div 2 MSB-first, div 1 LSB-first)
// each driving a behavioural 74HC595 shift/storage register model.
module tb_hc595_serializer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hc595_serializer_if a_if();
    hc595_serializer_if b_if();

    hc595_serializer #(.CLK_DIV(2), .MSB_FIRST(1'b1)) u_a (.CLK(clk), .Rst(rst), .bus(a_if.slave));
    hc595_serializer #(.CLK_DIV(1), .MSB_FIRST(1'b0)) u_b (.CLK(clk), .Rst(rst), .bus(b_if.slave));

    int n_tests = 0;
    int n_fail  = 0;

    // 74HC595 models; shift direction matches each instance's bit order
    logic [7:0] a_sh = 8'd0, a_latch = 8'd0, b_sh = 8'd0, b_latch = 8'd0;
    bit a_bits[$];
    bit b_bits[$];
    int a_sr = 0, a_rc = 0, a_sr_at_rc = 0, a_busy = 0, a_done = 0, a_rcw = 0;
    int b_sr = 0, b_rc = 0, b_sr_at_rc = 0, b_busy = 0, b_done = 0, b_rcw = 0;

    always @(posedge a_if.SRCLK) begin
        a_sh = {a_sh[6:0], a_if.SER};
        a_bits.push_back(a_if.SER);
        a_sr++;
    end
    always @(posedge a_if.RCLK) begin
        a_latch = a_sh;
        a_rc++;
        a_sr_at_rc = a_sr;
    end
    always @(posedge b_if.SRCLK) begin
        b_sh = {b_if.SER, b_sh[7:1]};
        b_bits.push_back(b_if.SER);
        b_sr++;
    end
    always @(posedge b_if.RCLK) begin
        b_latch = b_sh;
        b_rc++;
        b_sr_at_rc = b_sr;
    end
    always @(negedge clk) begin
        if (a_if.Busy === 1'b1) a_busy++;
        if (a_if.Done === 1'b1) a_done++;
        if (a_if.RCLK === 1'b1) a_rcw++;
        if (b_if.Busy === 1'b1) b_busy++;
        if (b_if.Done === 1'b1) b_done++;
        if (b_if.RCLK === 1'b1) b_rcw++;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    task automatic clear_mon();
        a_bits.delete(); b_bits.delete();
        a_sr = 0; a_rc = 0; a_sr_at_rc = 0; a_busy = 0; a_done = 0; a_rcw = 0;
        b_sr = 0; b_rc = 0; b_sr_at_rc = 0; b_busy = 0; b_done = 0; b_rcw = 0;
    endtask

    function automatic logic [7:0] a_order();
        logic [7:0] v = 8'd0;
        foreach (a_bits[i]) v = {v[6:0], a_bits[i]};
        return v;
    endfunction

    function automatic logic [7:0] b_order();
        logic [7:0] v = 8'd0;
        foreach (b_bits[i]) v = {v[6:0], b_bits[i]};
        return v;
    endfunction

    task automatic pulse_load(input bit sel_b, input logic [7:0] d);
        @(negedge clk);
        if (sel_b) begin b_if.Data = d; b_if.Load = 1'b1; end
        else       begin a_if.Data = d; a_if.Load = 1'b1; end
        @(negedge clk);
        a_if.Load = 1'b0;
        b_if.Load = 1'b0;
    endtask

    task automatic wait_done(input bit sel_b, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(negedge clk);
            if ((sel_b ? b_if.Done : a_if.Done) === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        a_if.Data = 8'h00; a_if.Load = 1'b0;
        b_if.Data = 8'h00; b_if.Load = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({a_if.Busy, a_if.Done, a_if.SER, a_if.SRCLK, a_if.RCLK} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_a outputs got=%b exp=00000",
                     {a_if.Busy, a_if.Done, a_if.SER, a_if.SRCLK, a_if.RCLK});
        end
        n_tests++;
        if ({b_if.Busy, b_if.Done, b_if.SER, b_if.SRCLK, b_if.RCLK} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_b outputs got=%b exp=00000",
                     {b_if.Busy, b_if.Done, b_if.SER, b_if.SRCLK, b_if.RCLK});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({a_if.Busy, a_if.SRCLK, a_if.RCLK} !== 3'b0) begin
            n_fail++;
            $display("FAIL idle_no_load got=%b exp=000", {a_if.Busy, a_if.SRCLK, a_if.RCLK});
        end
    endtask

    task automatic test_msb_a5();
        bit seen;
        clear_mon();
        pulse_load(1'b0, 8'hA5);
        wait_done(1'b0, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL a5_done timeout got=0 exp=1"); end
        @(negedge clk);
        n_tests++;
        if (a_order() !== 8'b10100101) begin n_fail++; $display("FAIL a5_bits got=%b exp=10100101", a_order()); end
        n_tests++;
        if (a_sr !== 8) begin n_fail++; $display("FAIL a5_srclk_rises got=%0d exp=8", a_sr); end
        n_tests++;
        if (a_rc !== 1 || a_sr_at_rc !== 8) begin
            n_fail++; $display("FAIL a5_rclk got=%0d rises after %0d srclk exp=1 after 8", a_rc, a_sr_at_rc);
        end
        n_tests++;
        if (a_rcw !== 2) begin n_fail++; $display("FAIL a5_rclk_width got=%0d exp=2", a_rcw); end
        n_tests++;
        if (a_busy !== 34) begin n_fail++; $display("FAIL a5_busy_cycles got=%0d exp=34", a_busy); end
        n_tests++;
        if (a_done !== 1) begin n_fail++; $display("FAIL a5_done_width got=%0d exp=1", a_done); end
        n_tests++;
        if (a_latch !== 8'hA5) begin n_fail++; $display("FAIL a5_latch got=%h exp=a5", a_latch); end
    endtask

    task automatic test_lsb_01();
        bit seen;
        clear_mon();
        pulse_load(1'b1, 8'h01);
        wait_done(1'b1, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL lsb01_done timeout got=0 exp=1"); end
        @(negedge clk);
        n_tests++;
        if (b_order() !== 8'b10000000) begin n_fail++; $display("FAIL lsb01_bits got=%b exp=10000000", b_order()); end
        n_tests++;
        if (b_latch !== 8'h01) begin n_fail++; $display("FAIL lsb01_latch got=%h exp=01", b_latch); end
    endtask

    task automatic test_div1_5a();
        bit seen;
        clear_mon();
        pulse_load(1'b1, 8'h5A);
        wait_done(1'b1, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL div1_done timeout got=0 exp=1"); end
        @(negedge clk);
        n_tests++;
        if (b_busy !== 17) begin n_fail++; $display("FAIL div1_busy_cycles got=%0d exp=17", b_busy); end
        n_tests++;
        if (b_sr !== 8 || b_rc !== 1 || b_sr_at_rc !== 8) begin
            n_fail++; $display("FAIL div1_edges got=%0d/%0d/%0d exp=8/1/8", b_sr, b_rc, b_sr_at_rc);
        end
        n_tests++;
        if (b_rcw !== 1 || b_done !== 1) begin
            n_fail++; $display("FAIL div1_pulse_widths got=%0d/%0d exp=1/1", b_rcw, b_done);
        end
        n_tests++;
        if (b_order() !== 8'b01011010) begin n_fail++; $display("FAIL div1_bits got=%b exp=01011010", b_order()); end
        n_tests++;
        if (b_latch !== 8'h5A) begin n_fail++; $display("FAIL div1_latch got=%h exp=5a", b_latch); end
    endtask

    task automatic test_back_to_back();
        bit seen;
        clear_mon();
        @(negedge clk);
        a_if.Data = 8'hFF; a_if.Load = 1'b1;
        @(negedge clk);
        a_if.Data = 8'h00;
        wait_done(1'b0, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL b2b_first_done timeout got=0 exp=1"); end
        n_tests++;
        if (a_latch !== 8'hFF || a_if.Busy !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first latch=%h busy=%b exp latch=ff busy=0", a_latch, a_if.Busy);
        end
        @(negedge clk);
        a_if.Load = 1'b0;
        n_tests++;
        if (a_if.Busy !== 1'b1) begin n_fail++; $display("FAIL b2b_restart busy got=%b exp=1", a_if.Busy); end
        wait_done(1'b0, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL b2b_second_done timeout got=0 exp=1"); end
        @(negedge clk);
        n_tests++;
        if (a_latch !== 8'h00) begin n_fail++; $display("FAIL b2b_second_latch got=%h exp=00", a_latch); end
        n_tests++;
        if (a_sr !== 16 || a_rc !== 2 || a_busy !== 68) begin
            n_fail++; $display("FAIL b2b_counts got=%0d/%0d/%0d exp=16/2/68", a_sr, a_rc, a_busy);
        end
    endtask

    task automatic test_load_ignored();
        bit seen;
        clear_mon();
        pulse_load(1'b0, 8'hC3);
        repeat (8) @(negedge clk);
        a_if.Data = 8'h3C; a_if.Load = 1'b1;
        @(negedge clk);
        a_if.Load = 1'b0;
        wait_done(1'b0, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL ign_done timeout got=0 exp=1"); end
        @(negedge clk);
        n_tests++;
        if (a_latch !== 8'hC3) begin n_fail++; $display("FAIL ign_latch got=%h exp=c3", a_latch); end
        n_tests++;
        if (a_order() !== 8'b11000011) begin n_fail++; $display("FAIL ign_bits got=%b exp=11000011", a_order()); end
        repeat (10) @(negedge clk);
        n_tests++;
        if (a_if.Busy !== 1'b0 || a_sr !== 8 || a_busy !== 34) begin
            n_fail++; $display("FAIL ign_not_queued busy=%b sr=%0d busycyc=%0d exp 0/8/34", a_if.Busy, a_sr, a_busy);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        bit reached;
        clear_mon();
        pulse_load(1'b0, 8'h96);
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(negedge clk);
            if (a_sr >= 4) reached = 1'b1;
        end
        n_tests++;
        if (!reached || a_sr !== 4) begin n_fail++; $display("FAIL rstmid_fourth_rise got=%0d exp=4", a_sr); end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({a_if.Busy, a_if.Done, a_if.SER, a_if.SRCLK, a_if.RCLK} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_async got=%b exp=00000",
                               {a_if.Busy, a_if.Done, a_if.SER, a_if.SRCLK, a_if.RCLK});
        end
        repeat (5) @(negedge clk);
        n_tests++;
        if (a_rc !== 0 || a_latch !== 8'hC3) begin
            n_fail++; $display("FAIL rstmid_no_latch rclk=%0d latch=%h exp 0/c3", a_rc, a_latch);
        end
        clear_mon();
        rst = 1'b1;
        a_if.Data = 8'h69; a_if.Load = 1'b1;
        @(negedge clk);
        a_if.Load = 1'b0;
        n_tests++;
        if (a_if.Busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_first_load busy got=%b exp=1", a_if.Busy); end
        wait_done(1'b0, seen);
        n_tests++;
        if (!seen) begin n_fail++; $display("FAIL rstmid_done timeout got=0 exp=1"); end
        @(negedge clk);
        n_tests++;
        if (a_latch !== 8'h69 || a_sr !== 8 || a_busy !== 34) begin
            n_fail++; $display("FAIL rstmid_recover latch=%h sr=%0d busy=%0d exp 69/8/34", a_latch, a_sr, a_busy);
        end
    endtask

    initial begin
        test_reset();
        test_msb_a5();
        test_lsb_01();
        test_div1_5a();
        test_back_to_back();
        test_load_ignored();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
